// File: rtl/custom_display_axi.sv
// rtl/custom_display_axi.sv - AXI4-Lite slave driving a multiplexed seven-segment display
// Registers: CTRL, VALUE, DIVIDER, STATUS; digits scanned at a programmable rate.
module custom_display_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_DIGITS         = 8,
  parameter int RESET_DIV          = 100000,
  parameter int ACTIVE_LOW         = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [6:0]                      seg,
  output logic                            dp
);

  localparam logic        INV        = (ACTIVE_LOW != 0);
  localparam logic [31:0] CTRL_MASK  = 32'h0000_FF03;
  localparam logic [31:0] VALUE_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                       : ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);
  localparam logic [23:0] DIV_RST    = 24'(RESET_DIV);
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic                  awready_q, awready_d, bvalid_q, bvalid_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           ctrl_q, ctrl_d, value_q, value_d;
  logic [23:0]           div_q, div_d, div_new;
  logic [23:0]           cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, an_act, lz;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  wr_hs, rd_hs, blank;
  logic [1:0]            wr_sel, rd_sel;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // lz[i]: digit i and every digit above it are zero
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    lz   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun  = zrun & (value_q[4*i +: 4] == 4'h0);
      lz[i] = zrun;
    end
  end

  always_comb begin
    wr_sel    = S_AXI_AWADDR[3:2];
    rd_sel    = S_AXI_ARADDR[3:2];
    wr_hs     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_hs     = arready_q & S_AXI_ARVALID;
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    value_d   = value_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_hs) bvalid_d = 1'b1;

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      case (rd_sel)
        2'd0:    rdata_d = ctrl_q;
        2'd1:    rdata_d = value_q;
        2'd2:    rdata_d = {8'h00, div_q};
        default: rdata_d = {cnt_q, 5'b00000, idx_q};
      endcase
    end

    div_new = div_q;
    for (int b = 0; b < 3; b++) begin
      if (S_AXI_WSTRB[b]) div_new[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end

    if (wr_hs) begin
      case (wr_sel)
        2'd0:    ctrl_d  = wmerge(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB) & CTRL_MASK;
        2'd1:    value_d = wmerge(value_q, S_AXI_WDATA, S_AXI_WSTRB) & VALUE_MASK;
        2'd2:    div_d   = (div_new == 24'd0) ? 24'd1 : div_new;
        default: ;
      endcase
    end

    if (!ctrl_q[0]) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (wr_hs && wr_sel == 2'd2) begin
      cnt_d = '0;
    end else if (cnt_q == div_q - 24'd1) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end

    // Display drive is computed active-high, then folded to the board polarity
    for (int i = 0; i < NUM_DIGITS; i++) an_act[i] = (idx_q == 3'(i));
    blank = ctrl_q[1] & (idx_q != 3'd0) & lz[idx_q];
    if (ctrl_q[0]) begin
      an_d  = an_act ^ {NUM_DIGITS{INV}};
      seg_d = (blank ? 7'h00 : hex_glyph(value_q[{idx_q, 2'b00} +: 4])) ^ {7{INV}};
      dp_d  = ctrl_q[{2'b01, idx_q}] ^ INV;
    end else begin
      an_d  = {NUM_DIGITS{INV}};
      seg_d = {7{INV}};
      dp_d  = INV;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      value_q   <= '0;
      div_q     <= DIV_RST;
      cnt_q     <= '0;
      idx_q     <= '0;
      an_q      <= {NUM_DIGITS{INV}};
      seg_q     <= {7{INV}};
      dp_q      <= INV;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      value_q   <= value_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign an            = an_q;
  assign seg           = seg_q;
  assign dp            = dp_q;

endmodule

// File: tb/tb_custom_display_axi.sv
// tb/tb_custom_display_axi.sv - directed table-driven bench for custom_display_axi
module tb_custom_display_axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  custom_display_axi #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_DIGITS(8),
    .RESET_DIV(100000), .ACTIVE_LOW(1)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[n];
  endfunction

  // Active-high segment pattern expected on digit d
  function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d, input bit blz);
    bit lead;
    lead = (d != 0);
    for (int k = d; k < 8; k++) if (v[4*k +: 4] != 4'h0) lead = 0;
    if (blz && lead) return 7'h00;
    return glyph(v[4*d +: 4]);
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit hs;
    hs = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = awready && wready;
    end
    check("wr_addr_handshake", 32'(hs), 32'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    hs = 0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = bvalid;
    end
    check("wr_bvalid", 32'(hs), 32'd1);
    check("wr_bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    bit hs;
    hs = 0;
    araddr = addr; arvalid = 1;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = arready;
    end
    check("rd_addr_handshake", 32'(hs), 32'd1);
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    hs = 0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = rvalid;
    end
    check("rd_rvalid", 32'(hs), 32'd1);
    check("rd_rresp", 32'(rresp), 32'd0);
    data = rdata;
    @(posedge clk); #1;
    rready = 0;
  endtask

  // Caller must be 1ns after the edge that closed the enabling CTRL write
  task automatic scan_check(input string tag, input int period, input logic [31:0] val,
                            input bit blz, input logic [7:0] dpm, input int nsamp);
    int d;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    for (int j = 0; j < nsamp; j++) begin
      d     = (j / period) % 8;
      e_an  = ~(8'h01 << d);
      e_seg = ~exp_seg(val, d, blz);
      check($sformatf("%s_an_s%0d", tag, j), 32'(an), 32'(e_an));
      check($sformatf("%s_seg_s%0d", tag, j), 32'(seg), 32'(e_seg));
      check($sformatf("%s_dp_s%0d", tag, j), 32'(dp), dpm[d] ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic setup_scan(input logic [31:0] val, input logic [31:0] div, input logic [31:0] ctrl);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, val, 4'hF);
    axi_write(4'h8, div, 4'hF);
    axi_write(4'h0, ctrl, 4'hF);
  endtask

  typedef struct {
    bit          do_wr;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [3:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    vecs = '{
      '{0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h0},
      '{0, 4'h0, 32'h0,        4'h0, 4'h4, 32'h0},
      '{0, 4'h0, 32'h0,        4'h0, 4'h8, 32'd100000},
      '{0, 4'h0, 32'h0,        4'h0, 4'hC, 32'h0},
      '{1, 4'h0, 32'h1,        4'hF, 4'h0, 32'h1},
      '{1, 4'h4, 32'h2,        4'hF, 4'h4, 32'h2},
      '{1, 4'h8, 32'h3,        4'hF, 4'h8, 32'h3},
      '{0, 4'h0, 32'h0,        4'h0, 4'h0, 32'h1},
      '{1, 4'h0, 32'hFFFFFFFF, 4'hF, 4'h0, 32'h0000FF03},
      '{1, 4'h4, 32'h0,        4'hF, 4'h4, 32'h0},
      '{1, 4'h4, 32'hFFFFFFFF, 4'h2, 4'h4, 32'h0000FF00},
      '{1, 4'h8, 32'h0,        4'hF, 4'h8, 32'h1},
      '{1, 4'h8, 32'h12345678, 4'hF, 4'h8, 32'h00345678},
      '{1, 4'h8, 32'h000000AB, 4'h1, 4'h8, 32'h003456AB},
      '{1, 4'hC, 32'hFFFFFFFF, 4'hF, 4'h8, 32'h003456AB},
      '{1, 4'h0, 32'h0,        4'hF, 4'hC, 32'h0},
      '{1, 4'h4, 32'h0F0F0F0F, 4'hC, 4'h4, 32'h0F0FFF00},
      '{1, 4'h0, 32'h12345678, 4'h3, 4'h0, 32'h00005600}
    };

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_wr) axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws);
      axi_read(vecs[i].ra, rd);
      check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
    end

    setup_scan(32'h12345678, 32'd4, 32'h1);
    scan_check("hex", 4, 32'h12345678, 0, 8'h00, 40);

    setup_scan(32'h00000507, 32'd2, 32'h0103);
    scan_check("blank", 2, 32'h00000507, 1, 8'h01, 20);

    setup_scan(32'h89ABCDEF, 32'd0, 32'hFF01);
    scan_check("div0", 1, 32'h89ABCDEF, 0, 8'hFF, 10);

    // DIVIDER rewrite mid-period: STATUS sampled the cycle after shows counter 0
    axi_write(4'h8, 32'd50, 4'hF);
    repeat (20) @(posedge clk);
    #1;
    awaddr = 4'h8; wdata = 32'd50; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    check("mid_awready", 32'(awready), 32'd1);
    araddr = 4'hC; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    check("mid_arready", 32'(arready), 32'd1);
    check("mid_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    arvalid = 0; bready = 0; rready = 1;
    check("mid_rvalid", 32'(rvalid), 32'd1);
    check("mid_status_cnt", rdata >> 8, 32'd0);
    @(posedge clk); #1;
    rready = 0;

    // Write response backpressure with a second write already presented
    awaddr = 4'h4; wdata = 32'hAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    check("bp_w_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    wdata = 32'hBB;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_w_bvalid_%0d", k), 32'(bvalid), 32'd1);
      check($sformatf("bp_w_awready_%0d", k), 32'(awready), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    begin
      bit hs;
      hs = 0;
      for (int k = 0; k < 5 && !hs; k++) begin
        hs = awready;
        if (!hs) begin @(posedge clk); #1; end
      end
      check("bp_w_second_hs", 32'(hs), 32'd1);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    check("bp_w_second_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    bready = 0;

    // Read data backpressure
    araddr = 4'h4; arvalid = 1;
    @(posedge clk); #1;
    check("bp_r_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_r_rvalid_%0d", k), 32'(rvalid), 32'd1);
      check($sformatf("bp_r_arready_%0d", k), 32'(arready), 32'd0);
      check($sformatf("bp_r_rdata_%0d", k), rdata, 32'hBB);
      @(posedge clk); #1;
    end
    rready = 1; arvalid = 0;
    @(posedge clk); #1;
    rready = 0;
    check("bp_r_rvalid_drop", 32'(rvalid), 32'd0);

    // Asynchronous reset mid-scan with a read response outstanding
    araddr = 4'h0; arvalid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arvalid = 0;
    check("ar_pre_rvalid", 32'(rvalid), 32'd1);
    #2 rst_n = 0;
    #1;
    check("ar_rvalid", 32'(rvalid), 32'd0);
    check("ar_rdata", rdata, 32'd0);
    check("ar_awready", 32'(awready), 32'd0);
    check("ar_arready", 32'(arready), 32'd0);
    check("ar_bvalid", 32'(bvalid), 32'd0);
    check("ar_an", 32'(an), 32'hFF);
    check("ar_seg", 32'(seg), 32'h7F);
    check("ar_dp", 32'(dp), 32'd1);
    @(posedge clk); #1;
    rst_n = 1;
    axi_read(4'h0, rd);
    check("ar_ctrl", rd, 32'h0);
    axi_read(4'h8, rd);
    check("ar_div", rd, 32'd100000);
    axi_read(4'hC, rd);
    check("ar_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
